// File: rtl/jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// jogo_sequencia_param
//   Sequence-memory game. The player must repeat a stored sequence of one-hot
//   button presses. In modo=0 every attempt covers the whole sequence. In
//   modo=1 the game runs progressive rounds: round r asks for moves 0..r.
//   A wrong press, a missed move deadline or completing the last round ends
//   the game in one of the FIM_* states. The result flag stays held there
//   until the next jogar edge.
//
// Ports
//   clock         system clock, rising edge
//   reset         asynchronous active-low reset
//   jogar         start/restart request (level, edge-detected here)
//   modo          0 = full sequence, 1 = progressive rounds (sampled in PREPARA)
//   escreve       sequence-memory write strobe (INICIAL / FIM_* only)
//   end_escrita   write address
//   dado_escrita  one-hot expected button for that address
//   botoes        player buttons, active-high, synchronous to clock
//   leds          registered copy of botoes while waiting for a move
//   ganhou/perdeu/timeout  mutually exclusive result flags
//   pronto        game finished (any result flag)
//   db_rodada     current round index
//   db_jogada     current move index within the round
//   db_estado     FSM state encoding
// ---------------------------------------------------------------------------
module jogo_sequencia_param #(
    parameter  int N_BOTOES       = 4,
    parameter  int PROFUNDIDADE   = 16,
    parameter  int TIMEOUT_CICLOS = 3000,
    localparam int AW             = (PROFUNDIDADE > 1) ? $clog2(PROFUNDIDADE) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                jogar,
    input  logic                modo,
    input  logic                escreve,
    input  logic [AW-1:0]       end_escrita,
    input  logic [N_BOTOES-1:0] dado_escrita,
    input  logic [N_BOTOES-1:0] botoes,
    output logic [N_BOTOES-1:0] leds,
    output logic                ganhou,
    output logic                perdeu,
    output logic                timeout,
    output logic                pronto,
    output logic [AW-1:0]       db_rodada,
    output logic [AW-1:0]       db_jogada,
    output logic [3:0]          db_estado
);

    typedef enum logic [3:0] {
        INICIAL        = 4'h0,
        PREPARA        = 4'h1,
        ESPERA_JOGADA  = 4'h2,
        COMPARA        = 4'h3,
        PROXIMA_JOGADA = 4'h4,
        PROXIMA_RODADA = 4'h5,
        FIM_GANHOU     = 4'hA,
        FIM_PERDEU     = 4'hE,
        FIM_TIMEOUT    = 4'hF
    } estado_t;

    // Counter only has to reach TIMEOUT_CICLOS-1; the extra headroom keeps
    // the limit representable for any legal TIMEOUT_CICLOS.
    localparam int            TW     = $clog2(TIMEOUT_CICLOS + 1);
    localparam logic [TW-1:0] LIMITE = TW'(TIMEOUT_CICLOS - 1);
    localparam logic [AW-1:0] ULTIMA = AW'(PROFUNDIDADE - 1);

    estado_t             estado, proximo;
    logic [N_BOTOES-1:0] mem [PROFUNDIDADE];
    logic [N_BOTOES-1:0] jogada_reg;
    logic [TW-1:0]       contador;
    logic                jogar_d;
    logic                botoes_d;

    logic jogar_borda;
    logic jogada_det;
    logic em_repouso;
    logic acerto;
    logic expirou;

    assign jogar_borda = jogar & ~jogar_d;
    // botoes_d tracks the buttons in every state, so a press that started
    // before ESPERA_JOGADA never looks like a fresh 0->1 edge there.
    assign jogada_det  = (estado == ESPERA_JOGADA) & (|botoes) & ~botoes_d;
    assign em_repouso  = (estado == INICIAL) || (estado == FIM_GANHOU) ||
                         (estado == FIM_PERDEU) || (estado == FIM_TIMEOUT);
    assign acerto      = (jogada_reg == mem[db_jogada]);
    assign expirou     = (contador == LIMITE);

    // -------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) estado <= INICIAL;
        else        estado <= proximo;
    end

    // -------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------
    always_comb begin
        // NOTE: default first so no path leaves proximo unassigned (no latch).
        proximo = estado;
        unique case (estado)
            INICIAL, FIM_GANHOU, FIM_PERDEU, FIM_TIMEOUT:
                if (jogar_borda) proximo = PREPARA;
            PREPARA:
                proximo = ESPERA_JOGADA;
            ESPERA_JOGADA:
                // A press on the last allowed cycle still counts as a move.
                if (jogada_det)   proximo = COMPARA;
                else if (expirou) proximo = FIM_TIMEOUT;
            COMPARA:
                if (!acerto)                   proximo = FIM_PERDEU;
                else if (db_jogada < db_rodada) proximo = PROXIMA_JOGADA;
                else if (db_rodada == ULTIMA)   proximo = FIM_GANHOU;
                else                            proximo = PROXIMA_RODADA;
            PROXIMA_JOGADA, PROXIMA_RODADA:
                proximo = ESPERA_JOGADA;
            default:
                proximo = INICIAL;
        endcase
    end

    // -------------------------------------------------------------------
    // Datapath: memory, edge registers, counters, result flags
    // -------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            // NOTE: the sequence memory is cleared on reset on purpose, so it
            // is built from flops rather than a RAM macro.
            for (int i = 0; i < PROFUNDIDADE; i++) mem[i] <= '0;
            jogada_reg <= '0;
            contador   <= '0;
            jogar_d    <= 1'b0;
            botoes_d   <= 1'b0;
            leds       <= '0;
            ganhou     <= 1'b0;
            perdeu     <= 1'b0;
            timeout    <= 1'b0;
            db_rodada  <= '0;
            db_jogada  <= '0;
        end else begin
            jogar_d  <= jogar;
            botoes_d <= |botoes;
            leds     <= (estado == ESPERA_JOGADA) ? botoes : '0;

            if (escreve && em_repouso && (end_escrita <= ULTIMA))
                mem[end_escrita] <= dado_escrita;

            unique case (estado)
                PREPARA: begin
                    db_jogada <= '0;
                    contador  <= '0;
                    ganhou    <= 1'b0;
                    perdeu    <= 1'b0;
                    timeout   <= 1'b0;
                    db_rodada <= modo ? '0 : ULTIMA;
                end
                ESPERA_JOGADA: begin
                    if (jogada_det)       jogada_reg <= botoes;
                    else if (!expirou)    contador   <= contador + 1'b1;
                    if (proximo == FIM_TIMEOUT) timeout <= 1'b1;
                end
                COMPARA: begin
                    if (proximo == FIM_PERDEU) perdeu <= 1'b1;
                    if (proximo == FIM_GANHOU) ganhou <= 1'b1;
                end
                PROXIMA_JOGADA: begin
                    db_jogada <= db_jogada + 1'b1;
                    contador  <= '0;
                end
                PROXIMA_RODADA: begin
                    db_rodada <= db_rodada + 1'b1;
                    db_jogada <= '0;
                    contador  <= '0;
                end
                default: ;
            endcase
        end
    end

    assign pronto    = ganhou | perdeu | timeout;
    assign db_estado = estado;

endmodule

// File: tb/tb_jogo_sequencia_param.sv
// ---------------------------------------------------------------------------
// tb_jogo_sequencia_param
//   Self-checking bench for jogo_sequencia_param with N_BOTOES=4,
//   PROFUNDIDADE=4, TIMEOUT_CICLOS=20 and memory 0001,0010,0100,1000.
//   A winning progressive game is table-driven; the loss, timeout, hold,
//   ignored-input and reset cases are hand-written sequences. Each move's
//   expected outcome is queued when the press is driven and popped when the
//   result appears two edges after detection.
// ---------------------------------------------------------------------------
module tb_jogo_sequencia_param;

    localparam int NB = 4;
    localparam int PR = 4;
    localparam int TO = 20;

    logic          clock;
    logic          reset;
    logic          jogar;
    logic          modo;
    logic          escreve;
    logic [1:0]    end_escrita;
    logic [NB-1:0] dado_escrita;
    logic [NB-1:0] botoes;
    logic [NB-1:0] leds;
    logic          ganhou, perdeu, timeout, pronto;
    logic [1:0]    db_rodada, db_jogada;
    logic [3:0]    db_estado;

    jogo_sequencia_param #(
        .N_BOTOES(NB), .PROFUNDIDADE(PR), .TIMEOUT_CICLOS(TO)
    ) dut (
        .clock(clock), .reset(reset), .jogar(jogar), .modo(modo),
        .escreve(escreve), .end_escrita(end_escrita), .dado_escrita(dado_escrita),
        .botoes(botoes), .leds(leds), .ganhou(ganhou), .perdeu(perdeu),
        .timeout(timeout), .pronto(pronto), .db_rodada(db_rodada),
        .db_jogada(db_jogada), .db_estado(db_estado)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] estado;
        logic       ganhou;
        logic       perdeu;
        logic       timeout;
        logic       pronto;
        logic [1:0] rodada;
        logic [1:0] jogada;
    } outs_t;

    typedef struct {
        logic [3:0] botoes;
        logic [3:0] estado;
        logic [1:0] rodada;
        logic [1:0] jogada;
    } vec_t;

    int    n_checks = 0;
    int    n_pass   = 0;
    outs_t sb_q[$];
    vec_t  win_tab[10];

    task automatic check(input string nome, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) $display("FAIL %s: got %h, expected %h", nome, got, exp);
        else             n_pass++;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic outs_t snap();
        outs_t o;
        o.estado  = db_estado;
        o.ganhou  = ganhou;
        o.perdeu  = perdeu;
        o.timeout = timeout;
        o.pronto  = pronto;
        o.rodada  = db_rodada;
        o.jogada  = db_jogada;
        return o;
    endfunction

    function automatic outs_t exp_outs(input logic [3:0] e, input logic [1:0] r, input logic [1:0] j);
        outs_t o;
        o.estado  = e;
        o.ganhou  = (e == 4'hA);
        o.perdeu  = (e == 4'hE);
        o.timeout = (e == 4'hF);
        o.pronto  = o.ganhou | o.perdeu | o.timeout;
        o.rodada  = r;
        o.jogada  = j;
        return o;
    endfunction

    // Start a game from INICIAL/FIM_* and land in ESPERA_JOGADA.
    task automatic start(input logic m, input logic [1:0] r_esp);
        modo  = m;
        jogar = 1'b1;
        tick();
        check("prepara_estado", db_estado, 4'h1);
        jogar = 1'b0;
        tick();
        check("inicio_jogo", snap(), exp_outs(4'h2, r_esp, 2'd0));
    endtask

    // One press from ESPERA_JOGADA; returns to ESPERA_JOGADA unless the
    // expected outcome is a FIM state.
    task automatic move(input logic [3:0] v, input logic [3:0] e,
                        input logic [1:0] r, input logic [1:0] j);
        outs_t x;
        botoes = v;
        sb_q.push_back(exp_outs(e, r, j));
        tick();
        check("compara_estado", db_estado, 4'h3);
        check("compara_leds", leds, v);
        check("compara_sem_pronto", pronto, 1'b0);
        botoes = '0;
        tick();
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("FAIL scoreboard: queue empty, expected one entry");
        end else begin
            x = sb_q.pop_front();
            check("resultado_jogada", snap(), x);
        end
        if (e == 4'h4 || e == 4'h5) tick();
    endtask

    initial begin
        int n;
        win_tab[0] = '{4'b0001, 4'h5, 2'd0, 2'd0};
        win_tab[1] = '{4'b0001, 4'h4, 2'd1, 2'd0};
        win_tab[2] = '{4'b0010, 4'h5, 2'd1, 2'd1};
        win_tab[3] = '{4'b0001, 4'h4, 2'd2, 2'd0};
        win_tab[4] = '{4'b0010, 4'h4, 2'd2, 2'd1};
        win_tab[5] = '{4'b0100, 4'h5, 2'd2, 2'd2};
        win_tab[6] = '{4'b0001, 4'h4, 2'd3, 2'd0};
        win_tab[7] = '{4'b0010, 4'h4, 2'd3, 2'd1};
        win_tab[8] = '{4'b0100, 4'h4, 2'd3, 2'd2};
        win_tab[9] = '{4'b1000, 4'hA, 2'd3, 2'd3};

        reset = 1'b0; jogar = 1'b0; modo = 1'b0; escreve = 1'b0;
        end_escrita = '0; dado_escrita = '0; botoes = '0;

        #12;
        check("reset_saidas", snap(), '0);
        check("reset_leds", leds, '0);
        reset = 1'b1;
        tick();

        for (int i = 0; i < PR; i++) begin
            escreve = 1'b1; end_escrita = 2'(i); dado_escrita = 4'(1 << i);
            tick();
        end
        escreve = 1'b0;
        check("inicial_apos_carga", db_estado, 4'h0);

        // Progressive win, table-driven.
        start(1'b1, 2'd0);
        for (int i = 0; i < 10; i++)
            move(win_tab[i].botoes, win_tab[i].estado, win_tab[i].rodada, win_tab[i].jogada);
        repeat (5) tick();
        check("ganhou_mantido", snap(), exp_outs(4'hA, 2'd3, 2'd3));

        // Restart from FIM_GANHOU clears flags; then lose in round 2, move 1.
        start(1'b1, 2'd0);
        move(4'b0001, 4'h5, 2'd0, 2'd0);
        move(4'b0001, 4'h4, 2'd1, 2'd0);
        move(4'b0010, 4'h5, 2'd1, 2'd1);
        move(4'b0001, 4'h4, 2'd2, 2'd0);
        move(4'b0100, 4'hE, 2'd2, 2'd1);

        // Full-sequence mode: timeout after exactly TO idle cycles.
        start(1'b0, 2'd3);
        move(4'b0001, 4'h4, 2'd3, 2'd0);
        for (n = 1; n <= 50; n++) begin
            tick();
            if (timeout) break;
        end
        check("timeout_ciclos", n, TO);
        check("timeout_estado", snap(), exp_outs(4'hF, 2'd3, 2'd1));
        repeat (3) tick();
        check("timeout_mantido", snap(), exp_outs(4'hF, 2'd3, 2'd1));

        // TO-1 idle cycles then a correct press: no timeout.
        start(1'b0, 2'd3);
        move(4'b0001, 4'h4, 2'd3, 2'd0);
        repeat (TO - 1) tick();
        check("quase_timeout", snap(), exp_outs(4'h2, 2'd3, 2'd1));
        move(4'b0010, 4'h4, 2'd3, 2'd1);

        // jogar edge mid-game is ignored; then a wrong press ends it.
        jogar = 1'b1; tick(); jogar = 1'b0; tick();
        check("jogar_ignorado", snap(), exp_outs(4'h2, 2'd3, 2'd2));
        move(4'b1000, 4'hE, 2'd3, 2'd2);

        // Multi-hot press is wrong.
        start(1'b0, 2'd3);
        move(4'b0011, 4'hE, 2'd3, 2'd0);

        // Held button is one move; modo change mid-game has no effect.
        start(1'b0, 2'd3);
        modo   = 1'b1;
        botoes = 4'b0001;
        repeat (10) tick();
        check("segurar_uma_jogada", snap(), exp_outs(4'h2, 2'd3, 2'd1));
        botoes = '0;
        tick();
        move(4'b0010, 4'h4, 2'd3, 2'd1);
        move(4'b0100, 4'h4, 2'd3, 2'd2);
        move(4'b1000, 4'hA, 2'd3, 2'd3);

        // escreve outside idle states is ignored; async reset mid-game.
        start(1'b1, 2'd0);
        move(4'b0001, 4'h5, 2'd0, 2'd0);
        move(4'b0001, 4'h4, 2'd1, 2'd0);
        move(4'b0010, 4'h5, 2'd1, 2'd1);
        escreve = 1'b1; end_escrita = 2'd0; dado_escrita = 4'b1000;
        tick();
        escreve = 1'b0;
        move(4'b0001, 4'h4, 2'd2, 2'd0);
        #2 reset = 1'b0;
        #1;
        check("reset_assincrono", snap(), '0);
        check("reset_assincrono_leds", leds, '0);
        #3 reset = 1'b1;
        repeat (3) tick();
        check("espera_jogar_pos_reset", snap(), '0);

        // Memory was cleared by reset, so any press is wrong.
        start(1'b1, 2'd0);
        move(4'b0001, 4'hE, 2'd0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/jogo_sequencia_param.md
JOGO_SEQUENCIA_PARAM -- requirements
Module: jogo_sequencia_param

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- N_BOTOES, 4, number of buttons/LEDs; legal range 2..8.
- PROFUNDIDADE, 16, sequence length; legal range 2..64.
- TIMEOUT_CICLOS, 3000, clock cycles allowed per move.
- AW, clog2(PROFUNDIDADE), address width (derived, not overridable).

REQ-002 Ports, one per line: name, direction, width, meaning.
- clock, input, 1, single system clock, rising edge.
- reset, input, 1, asynchronous active-low reset.
- jogar, input, 1, start/restart game; level, edge-detected internally.
- modo, input, 1, 0 = full sequence every attempt; 1 = progressive rounds.
- escreve, input, 1, sequence-memory write strobe; honoured only in INICIAL or a FIM state.
- end_escrita, input, AW, write address.
- dado_escrita, input, N_BOTOES, one-hot expected button for that address.
- botoes, input, N_BOTOES, player buttons, active-high, synchronous to clock.
- leds, output, N_BOTOES, registered copy of botoes while in ESPERA_JOGADA, else 0.
- ganhou, output, 1, game won.
- perdeu, output, 1, wrong move.
- timeout, output, 1, move not made in time.
- pronto, output, 1, game finished (ganhou|perdeu|timeout).
- db_rodada, output, AW, current round index.
- db_jogada, output, AW, current move index within the round.
- db_estado, output, 4, state encoding per REQ-006.

Function
REQ-003 Sequence memory SHALL be PROFUNDIDADE x N_BOTOES registers, written synchronously when escreve=1 in an allowed state; escreve is ignored elsewhere.
REQ-004 A move SHALL be detected on the first cycle in which |botoes goes 0->1 (registered previous value). The value sampled in that cycle is the move. Holding buttons generates no further moves.
REQ-005 A move SHALL be correct iff it equals mem[db_jogada] exactly. Multi-hot or partial presses are wrong.
REQ-006 States and encodings: INICIAL=0, PREPARA=1, ESPERA_JOGADA=2, COMPARA=3, PROXIMA_JOGADA=4, PROXIMA_RODADA=5, FIM_GANHOU=A, FIM_PERDEU=E, FIM_TIMEOUT=F.
REQ-007 Transitions:
- INICIAL/FIM_*: jogar rising edge -> PREPARA.
- PREPARA (1 cycle): clears db_jogada, the timeout counter, and the result flags. Sets db_rodada to 0 if modo=1, else to PROFUNDIDADE-1. Next state ESPERA_JOGADA.
- ESPERA_JOGADA: on a move, registers it -> COMPARA. If the counter reaches TIMEOUT_CICLOS-1 first -> FIM_TIMEOUT.
- COMPARA: wrong -> FIM_PERDEU. Correct and db_jogada<db_rodada -> PROXIMA_JOGADA. Correct and db_jogada==db_rodada: db_rodada==PROFUNDIDADE-1 -> FIM_GANHOU, else -> PROXIMA_RODADA.
- PROXIMA_JOGADA: db_jogada+1, clears counter -> ESPERA_JOGADA.
- PROXIMA_RODADA: db_rodada+1, db_jogada=0, clears counter -> ESPERA_JOGADA.
REQ-008 Latency: the result flag SHALL assert on the 2nd rising edge after the move-detection cycle (detect -> COMPARA -> FIM_*).
REQ-009 The timeout counter SHALL count only in ESPERA_JOGADA, saturate, and never wrap. TIMEOUT_CICLOS cycles without a move gives exactly one FIM_TIMEOUT entry.
REQ-010 ganhou, perdeu and timeout SHALL be mutually exclusive and held through the FIM state. pronto = ganhou|perdeu|timeout. All are cleared in PREPARA.
REQ-011 Counters SHALL be exactly AW bits. db_jogada never exceeds db_rodada; db_rodada never exceeds PROFUNDIDADE-1.
REQ-012 A jogar edge outside INICIAL/FIM_* SHALL be ignored. A move outside ESPERA_JOGADA SHALL be ignored, and a button already held when entering ESPERA_JOGADA is not a move.
REQ-013 modo SHALL be sampled only in PREPARA. Mid-game changes have no effect.

Reset
REQ-014 reset=0 SHALL asynchronously force INICIAL, counters 0, and all outputs 0, including leds and db_*. Sequence memory SHALL be cleared to 0.
REQ-015 Reset asserted mid-game SHALL abort immediately with no flag pulse. After release, a jogar edge is required to restart.
REQ-016 The jogar/botoes edge registers SHALL reset to 0, so a level already high at reset release counts as an edge.

Verification (bench: N_BOTOES=4, PROFUNDIDADE=4, TIMEOUT_CICLOS=20; memory loaded 0001,0010,0100,1000)
REQ-017 modo=1: all 10 moves correct (1+2+3+4) -> ganhou=1, pronto=1, db_estado=A, db_rodada=3.
REQ-018 modo=1: round 2, move 1 pressed 0100 instead of 0010 -> perdeu=1 two edges after detection, db_estado=E, db_rodada=2, db_jogada=1.
REQ-019 modo=0: first move correct, then no press for 20 cycles -> timeout=1, db_estado=F, db_jogada=1. With 19 idle cycles and then a correct press, no timeout.
REQ-020 Press 0011 as the first move -> perdeu=1. Holding 0001 for 10 cycles counts as one move only.
REQ-021 Drive reset=0 in ESPERA_JOGADA of round 2 -> db_estado=0 and all outputs 0 with no clock edge needed. escreve in ESPERA_JOGADA leaves memory unchanged. A jogar edge in FIM_GANHOU restarts the game with flags cleared.
